// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU sequencer: opcodes, ALU source select,
// FSM states and instruction field widths.
package cpu_pkg;

    localparam int unsigned OPC_W = 4;
    localparam int unsigned IMM_W = 8;

    typedef enum logic [3:0] {
        OpNop   = 4'h0,
        OpMvb   = 4'h1,
        OpLoad  = 4'h2,
        OpStore = 4'h3,
        OpXchg  = 4'h4,
        OpJmp   = 4'h5,
        OpJz    = 4'h6,
        OpJc    = 4'h7,
        OpJnz   = 4'h8,
        OpJnc   = 4'h9,
        OpMva   = 4'hA,
        OpAnd   = 4'hB,
        OpOr    = 4'hC,
        OpNot   = 4'hD,
        OpAdd   = 4'hE,
        OpSub   = 4'hF
    } opcode_e;

    typedef enum logic [2:0] {
        AluImm  = 3'd0,
        AluRam  = 3'd1,
        AluAnd  = 3'd2,
        AluOr   = 3'd3,
        AluNot  = 3'd4,
        AluAdd  = 3'd5,
        AluSub  = 3'd6,
        AluSwap = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        StHalt  = 2'd0,
        StFetch = 2'd1,
        StExec  = 2'd2,
        StMemrd = 2'd3
    } state_e;

endpackage

// File: rtl/cpu_ctrl_decode.sv
// Combinational opcode decoder; the parent gates every output with the EXEC state.
module cpu_ctrl_decode
    import cpu_pkg::*;
(
    input  logic [3:0] opcode,
    input  logic       z_in,
    input  logic       c_in,
    output logic       a_we,
    output logic       b_we,
    output logic       flag_we,
    output logic       ram_we,
    output logic       ram_re,
    output logic [2:0] alu_op,
    output logic       jump_taken,
    output logic       is_load
);

    always_comb begin
        a_we       = 1'b0;
        b_we       = 1'b0;
        flag_we    = 1'b0;
        ram_we     = 1'b0;
        ram_re     = 1'b0;
        alu_op     = AluImm;
        jump_taken = 1'b0;
        is_load    = 1'b0;
        unique case (opcode)
            OpNop:   ;
            OpMvb:   b_we = 1'b1;
            OpLoad:  begin ram_re = 1'b1; is_load = 1'b1; end
            OpStore: ram_we = 1'b1;
            OpXchg:  begin a_we = 1'b1; b_we = 1'b1; alu_op = AluSwap; end
            OpJmp:   jump_taken = 1'b1;
            OpJz:    jump_taken = z_in;
            OpJc:    jump_taken = c_in;
            OpJnz:   jump_taken = ~z_in;
            OpJnc:   jump_taken = ~c_in;
            OpMva:   a_we = 1'b1;
            OpAnd:   begin a_we = 1'b1; flag_we = 1'b1; alu_op = AluAnd; end
            OpOr:    begin a_we = 1'b1; flag_we = 1'b1; alu_op = AluOr;  end
            OpNot:   begin a_we = 1'b1; flag_we = 1'b1; alu_op = AluNot; end
            OpAdd:   begin a_we = 1'b1; flag_we = 1'b1; alu_op = AluAdd; end
            OpSub:   begin a_we = 1'b1; flag_we = 1'b1; alu_op = AluSub; end
            default: ;
        endcase
    end

endmodule

// File: rtl/cpu_ctrl.sv
// Multi-cycle fetch/execute sequencer owning PC, IR and the retired counter.
// Optional single-step input enabled by defining CPU_CTRL_STEP_EN.
module cpu_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned PC_W   = 10,
    parameter int unsigned IR_W   = 14,
    parameter int unsigned RAM_AW = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
`ifdef CPU_CTRL_STEP_EN
    input  logic              step,
`endif
    output logic              rom_req,
    output logic [PC_W-1:0]   rom_addr,
    input  logic              rom_ack,
    input  logic [IR_W-1:0]   rom_data,
    input  logic              z_in,
    input  logic              c_in,
    output logic [PC_W-1:0]   pc,
    output logic [IR_W-1:0]   ir,
    output logic [2:0]        alu_op,
    output logic [7:0]        imm,
    output logic              a_we,
    output logic              b_we,
    output logic              flag_we,
    output logic              ram_we,
    output logic              ram_re,
    output logic [RAM_AW-1:0] ram_addr,
    output logic              busy,
    output logic              halted,
    output logic [15:0]       retired
);

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [IR_W-1:0]   ir_q, ir_d;
    logic [15:0]       retired_q, retired_d;

    logic       dec_a_we, dec_b_we, dec_flag_we, dec_ram_we, dec_ram_re;
    logic [2:0] dec_alu_op;
    logic       dec_jump, dec_is_load;
    logic       start;
    logic       in_exec, in_memrd;

`ifdef CPU_CTRL_STEP_EN
    assign start = run | step;
`else
    assign start = run;
`endif

    cpu_ctrl_decode u_decode (
        .opcode     (ir_q[IR_W-1 -: OPC_W]),
        .z_in       (z_in),
        .c_in       (c_in),
        .a_we       (dec_a_we),
        .b_we       (dec_b_we),
        .flag_we    (dec_flag_we),
        .ram_we     (dec_ram_we),
        .ram_re     (dec_ram_re),
        .alu_op     (dec_alu_op),
        .jump_taken (dec_jump),
        .is_load    (dec_is_load)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        retired_d = retired_q;
        unique case (state_q)
            StHalt: begin
                if (start) state_d = StFetch;
            end
            StFetch: begin
                if (rom_ack) begin
                    ir_d    = rom_data;
                    pc_d    = pc_q + PC_W'(1);
                    state_d = StExec;
                end
            end
            StExec: begin
                if (dec_jump) pc_d = ir_q[PC_W-1:0];
                if (dec_is_load) begin
                    state_d = StMemrd;
                end else begin
                    retired_d = retired_q + 16'd1;
                    state_d   = run ? StFetch : StHalt;
                end
            end
            StMemrd: begin
                retired_d = retired_q + 16'd1;
                state_d   = run ? StFetch : StHalt;
            end
            default: state_d = StHalt;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StHalt;
            pc_q      <= '0;
            ir_q      <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            retired_q <= retired_d;
        end
    end

    // All outputs decode flopped state only, so strobes are clean single-cycle pulses.
    always_comb begin
        in_exec  = (state_q == StExec);
        in_memrd = (state_q == StMemrd);
        rom_req  = (state_q == StFetch);
        busy     = (state_q != StHalt);
        halted   = (state_q == StHalt);
        a_we     = (in_exec & dec_a_we) | in_memrd;
        b_we     = in_exec & dec_b_we;
        flag_we  = in_exec & dec_flag_we;
        ram_we   = in_exec & dec_ram_we;
        ram_re   = in_exec & dec_ram_re;
        alu_op   = AluImm;
        if (in_memrd)     alu_op = AluRam;
        else if (in_exec) alu_op = dec_alu_op;
    end

    assign rom_addr = pc_q;
    assign pc       = pc_q;
    assign ir       = ir_q;
    assign imm      = ir_q[IMM_W-1:0];
    assign ram_addr = ir_q[RAM_AW-1:0];
    assign retired  = retired_q;

endmodule

// File: tb/tb_cpu_ctrl.sv
// Self-checking bench for cpu_ctrl: opcode vector table, instruction-level random model,
// and hand sequences for timing, run/halt, reset-in-fetch and (optional) single step.
module tb_cpu_ctrl;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst, run, rom_ack, z_in, c_in;
    logic [13:0] rom_data;
    logic        rom_req, a_we, b_we, flag_we, ram_we, ram_re, busy, halted;
    logic [9:0]  rom_addr, pc;
    logic [13:0] ir;
    logic [2:0]  alu_op;
    logic [7:0]  imm;
    logic [3:0]  ram_addr;
    logic [15:0] retired;
`ifdef CPU_CTRL_STEP_EN
    logic        step;
`endif

    cpu_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
`ifdef CPU_CTRL_STEP_EN
        .step     (step),
`endif
        .rom_req  (rom_req),
        .rom_addr (rom_addr),
        .rom_ack  (rom_ack),
        .rom_data (rom_data),
        .z_in     (z_in),
        .c_in     (c_in),
        .pc       (pc),
        .ir       (ir),
        .alu_op   (alu_op),
        .imm      (imm),
        .a_we     (a_we),
        .b_we     (b_we),
        .flag_we  (flag_we),
        .ram_we   (ram_we),
        .ram_re   (ram_re),
        .ram_addr (ram_addr),
        .busy     (busy),
        .halted   (halted),
        .retired  (retired)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // Architectural model state
    logic [9:0]  mpc;
    logic [15:0] mret;

    typedef struct packed {
        logic a, b, f, rw, rr;
        logic [2:0] alu;
        logic load;
    } exp_t;

    typedef struct packed {
        logic [13:0] word;
        logic        z, c;
        logic [4:0]  stb;
        logic [2:0]  alu;
        logic        load;
        logic        taken;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t ref_exec(input logic [3:0] op);
        exp_t e;
        e = '0;
        e.alu = AluImm;
        case (op)
            4'h1: e.b = 1'b1;
            4'h2: begin e.rr = 1'b1; e.load = 1'b1; end
            4'h3: e.rw = 1'b1;
            4'h4: begin e.a = 1'b1; e.b = 1'b1; e.alu = AluSwap; end
            4'hA: e.a = 1'b1;
            4'hB: begin e.a = 1'b1; e.f = 1'b1; e.alu = AluAnd; end
            4'hC: begin e.a = 1'b1; e.f = 1'b1; e.alu = AluOr;  end
            4'hD: begin e.a = 1'b1; e.f = 1'b1; e.alu = AluNot; end
            4'hE: begin e.a = 1'b1; e.f = 1'b1; e.alu = AluAdd; end
            4'hF: begin e.a = 1'b1; e.f = 1'b1; e.alu = AluSub; end
            default: ;
        endcase
        return e;
    endfunction

    function automatic logic ref_taken(input logic [3:0] op, input logic z, input logic c);
        case (op)
            4'h5: return 1'b1;
            4'h6: return z;
            4'h7: return c;
            4'h8: return !z;
            4'h9: return !c;
            default: return 1'b0;
        endcase
    endfunction

    // Entered at a negedge with the DUT in FETCH; leaves at the negedge after completion.
    task automatic do_instr(input logic [13:0] word, input int delay, input logic z,
                            input logic c, input logic stop, input exp_t e, input logic taken);
        logic [9:0] npc;
        chk("fetch_req", rom_req, 1);
        chk("fetch_addr", rom_addr, mpc);
        chk("fetch_quiet", {a_we, b_we, flag_we, ram_we, ram_re}, 0);
        for (int i = 0; i < delay; i++) begin
            rom_ack = 1'b0;
            @(negedge clk);
            chk("wait_req", rom_req, 1);
            chk("wait_addr", rom_addr, mpc);
            chk("wait_quiet", {a_we, b_we, flag_we, ram_we, ram_re}, 0);
        end
        rom_ack  = 1'b1;
        rom_data = word;
        @(negedge clk);
        rom_ack  = 1'b0;
        rom_data = 14'($urandom);
        npc = mpc + 10'd1;
        chk("exec_ir", ir, word);
        chk("exec_pc", pc, npc);
        chk("exec_req", rom_req, 0);
        chk("exec_busy", busy, 1);
        chk("exec_strobes", {a_we, b_we, flag_we, ram_we, ram_re}, {e.a, e.b, e.f, e.rw, e.rr});
        if (e.a || e.b) chk("exec_alu", alu_op, e.alu);
        chk("exec_imm", imm, word[7:0]);
        chk("exec_ram_addr", ram_addr, word[3:0]);
        z_in = z;
        c_in = c;
        if (stop) run = 1'b0;
        if (taken) npc = word[9:0];
        @(negedge clk);
        if (e.load) begin
            chk("memrd_strobes", {a_we, b_we, flag_we, ram_we, ram_re}, 5'b10000);
            chk("memrd_alu", alu_op, AluRam);
            @(negedge clk);
        end
        mpc  = npc;
        mret = mret + 16'd1;
        chk("done_pc", pc, mpc);
        chk("done_retired", retired, mret);
        chk("done_halted", halted, stop);
        chk("done_req", rom_req, !stop);
    endtask

    task automatic run_model(input logic [13:0] word, input int delay, input logic z,
                             input logic c, input logic stop);
        do_instr(word, delay, z, c, stop, ref_exec(word[13:10]), ref_taken(word[13:10], z, c));
    endtask

    vec_t vecs[20];

    initial begin
        int unsigned t0;
        exp_t        ev;

        vecs[0]  = '{14'h0000, 1'b0, 1'b0, 5'b00000, AluImm,  1'b0, 1'b0};
        vecs[1]  = '{14'h0407, 1'b0, 1'b0, 5'b01000, AluImm,  1'b0, 1'b0};
        vecs[2]  = '{14'h080F, 1'b0, 1'b0, 5'b00001, AluImm,  1'b1, 1'b0};
        vecs[3]  = '{14'h0C03, 1'b0, 1'b0, 5'b00010, AluImm,  1'b0, 1'b0};
        vecs[4]  = '{14'h1000, 1'b0, 1'b0, 5'b11000, AluSwap, 1'b0, 1'b0};
        vecs[5]  = '{14'h1600, 1'b0, 1'b0, 5'b00000, AluImm,  1'b0, 1'b1};
        vecs[6]  = '{14'h1A00, 1'b1, 1'b0, 5'b00000, AluImm,  1'b0, 1'b1};
        vecs[7]  = '{14'h1A00, 1'b0, 1'b1, 5'b00000, AluImm,  1'b0, 1'b0};
        vecs[8]  = '{14'h1E00, 1'b0, 1'b1, 5'b00000, AluImm,  1'b0, 1'b1};
        vecs[9]  = '{14'h1E00, 1'b1, 1'b0, 5'b00000, AluImm,  1'b0, 1'b0};
        vecs[10] = '{14'h2200, 1'b0, 1'b1, 5'b00000, AluImm,  1'b0, 1'b1};
        vecs[11] = '{14'h2200, 1'b1, 1'b0, 5'b00000, AluImm,  1'b0, 1'b0};
        vecs[12] = '{14'h2600, 1'b1, 1'b0, 5'b00000, AluImm,  1'b0, 1'b1};
        vecs[13] = '{14'h2600, 1'b0, 1'b1, 5'b00000, AluImm,  1'b0, 1'b0};
        vecs[14] = '{14'h28AB, 1'b0, 1'b0, 5'b10000, AluImm,  1'b0, 1'b0};
        vecs[15] = '{14'h2C00, 1'b0, 1'b0, 5'b10100, AluAnd,  1'b0, 1'b0};
        vecs[16] = '{14'h3000, 1'b0, 1'b0, 5'b10100, AluOr,   1'b0, 1'b0};
        vecs[17] = '{14'h3400, 1'b0, 1'b0, 5'b10100, AluNot,  1'b0, 1'b0};
        vecs[18] = '{14'h3800, 1'b0, 1'b0, 5'b10100, AluAdd,  1'b0, 1'b0};
        vecs[19] = '{14'h3C00, 1'b0, 1'b0, 5'b10100, AluSub,  1'b0, 1'b0};

        rst = 1'b1; run = 1'b0; rom_ack = 1'b0; rom_data = '0; z_in = 1'b0; c_in = 1'b0;
`ifdef CPU_CTRL_STEP_EN
        step = 1'b0;
`endif
        #1;
        chk("rst_req", rom_req, 0);
        chk("rst_halted", halted, 1);
        chk("rst_busy", busy, 0);
        chk("rst_pc", pc, 0);
        chk("rst_ir", ir, 0);
        chk("rst_retired", retired, 0);
        chk("rst_strobes", {a_we, b_we, flag_we, ram_we, ram_re}, 0);

        @(negedge clk);
        rst = 1'b0;
        run = 1'b1;
        mpc = '0;
        mret = '0;
        @(negedge clk);

        // mva 5; mvb 4; add with a zero-wait ROM
        t0 = cyc;
        run_model(14'h2805, 0, 1'b0, 1'b0, 1'b0);
        run_model(14'h0404, 0, 1'b0, 1'b0, 1'b0);
        run_model(14'h3800, 0, 1'b0, 1'b0, 1'b0);
        chk("prog_cycles", cyc - t0, 6);
        chk("prog_pc", pc, 3);
        chk("prog_retired", retired, 3);

        // ROM answers 3 cycles late
        t0 = cyc;
        run_model(14'h2811, 3, 1'b0, 1'b0, 1'b0);
        run_model(14'h3000, 3, 1'b0, 1'b0, 1'b0);
        chk("slow_cycles", cyc - t0, 10);

        // load takes 3 cycles
        t0 = cyc;
        run_model(14'h080F, 0, 1'b0, 1'b0, 1'b0);
        chk("load_cycles", cyc - t0, 3);

        for (int i = 0; i < 20; i++) begin
            ev = '{vecs[i].stb[4], vecs[i].stb[3], vecs[i].stb[2], vecs[i].stb[1],
                   vecs[i].stb[0], vecs[i].alu, vecs[i].load};
            do_instr(vecs[i].word, i % 2, vecs[i].z, vecs[i].c, 1'b0, ev, vecs[i].taken);
        end

        for (int i = 0; i < 300; i++) begin
            run_model(14'($urandom), int'($urandom_range(0, 2)), 1'($urandom), 1'($urandom),
                      1'b0);
        end

        // Wrap 1023 -> 0, then drop run during EXEC of the instruction at 7
        run_model(14'h17FE, 0, 1'b0, 1'b0, 1'b0);
        run_model(14'h0000, 0, 1'b0, 1'b0, 1'b0);
        run_model(14'h0000, 0, 1'b0, 1'b0, 1'b0);
        chk("wrap_pc", pc, 0);
        run_model(14'h1407, 0, 1'b0, 1'b0, 1'b0);
        run_model(14'h2842, 1, 1'b0, 1'b0, 1'b1);
        chk("stop_pc", pc, 8);
        rom_ack = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("halt_req", rom_req, 0);
            chk("halt_halted", halted, 1);
            chk("halt_pc", pc, 8);
        end
        rom_ack = 1'b0;
        run = 1'b1;
        @(negedge clk);
        run_model(14'h0000, 0, 1'b0, 1'b0, 1'b0);

        // Reset while fetching from 0x3FF
        run_model(14'h17FF, 0, 1'b0, 1'b0, 1'b0);
        chk("pre_rst_addr", rom_addr, 10'h3FF);
        rom_ack = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_pc", pc, 0);
        chk("mid_rst_req", rom_req, 0);
        chk("mid_rst_retired", retired, 0);
        chk("mid_rst_halted", halted, 1);
        rom_ack = 1'b1;
        rom_data = 14'h2855;
        @(negedge clk);
        chk("rst_hold_ir", ir, 0);
        rom_ack = 1'b0;
        rst = 1'b0;
        mpc = '0;
        mret = '0;
        @(negedge clk);
        run_model(14'h2801, 0, 1'b0, 1'b0, 1'b0);

        // Finish halted; with step enabled, one pulse runs exactly one instruction
        run_model(14'h0000, 0, 1'b0, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        chk("idle_halted", halted, 1);
        chk("idle_retired", retired, mret);
`ifdef CPU_CTRL_STEP_EN
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        run_model(14'h3800, 0, 1'b0, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        chk("step_halted", halted, 1);
        chk("step_retired", retired, mret);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu_ctrl.md
# cpu_ctrl

Multi-cycle instruction sequencer for the 8-bit accumulator CPU (A/B registers, Z/C flags, 16×8 data RAM, 1024×14 program ROM).
- Owns PC and IR.
- Fetches from ROM over a request/acknowledge handshake and decodes the 4-bit opcode.
- Drives one-cycle write strobes into the A/B/flag/RAM datapath, so the datapath runs on a single clock edge.
- Adds run/halt control and a retired-instruction counter.

## Interface
- PC_W, 10, program counter / ROM address width
- IR_W, 14, instruction width (opcode IR[13:10], address IR[9:0], immediate IR[7:0])
- RAM_AW, 4, data RAM address width (taken from IR[RAM_AW-1:0])
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, asynchronous, active-high
- run  in  1  level; 1 = execute, 0 = stop at next instruction boundary
- rom_req  out  1  fetch request
- rom_addr  out  PC_W  fetch address (= pc)
- rom_ack  in  1  ROM data valid this cycle
- rom_data  in  IR_W  instruction word
- z_in, c_in  in  1 each  current datapath flags
- pc  out  PC_W  program counter
- ir  out  IR_W  current instruction
- alu_op  out  3  datapath source select: IMM, RAM, AND, OR, NOT, ADD, SUB, SWAP
- imm  out  8  IR[7:0]
- a_we, b_we, flag_we, ram_we, ram_re  out  1 each  one-cycle strobes
- ram_addr  out  RAM_AW  IR[RAM_AW-1:0]
- busy  out  1  1 in FETCH/EXEC/MEMRD
- halted  out  1  1 in HALT
- retired  out  16  completed-instruction count

## Operation
- States: HALT, FETCH, EXEC, MEMRD.
- HALT:
  - rom_req=0.
  - run=1 → FETCH.
- FETCH:
  - rom_req=1, rom_addr=pc, held stable until rom_ack.
  - On rom_ack: ir←rom_data; pc←pc+1, wrapping 1023→0; → EXEC.
- EXEC: strobes asserted for exactly this cycle, by opcode.
  - 0 nop: no strobes.
  - A mva: a_we, alu_op=IMM.
  - 1 mvb: b_we, alu_op=IMM.
  - 2 load: ram_re; → MEMRD.
  - 3 store: ram_we.
  - 4 xchg: a_we, b_we, alu_op=SWAP.
  - B/C/D/E/F (and/or/not/add/sub): a_we, flag_we, alu_op accordingly.
  - 5 jmp: pc←IR[9:0].
  - 6 jz / 7 jc / 8 jnz / 9 jnc: pc←IR[9:0] only if the tested flag condition holds on z_in/c_in this cycle.
- MEMRD: a_we with alu_op=RAM (synchronous RAM data available here).
- Instruction completion: last cycle of EXEC (or of MEMRD for load).
  - retired+1, wrapping 65535→0.
  - Next state: run=1 → FETCH, else → HALT.
- Strobe defaults: every strobe is 0 in all states other than those listed above.
- Address truncation: IR[9:RAM_AW] ignored for RAM accesses.

## Timing
- Reset (asynchronous, immediate):
  - state=HALT, pc=0, ir=0 (nop), retired=0.
  - rom_req=0, all strobes=0, busy=0, halted=1.
- Reset during FETCH: rom_req drops immediately; any later rom_ack is ignored until the next FETCH.
- Latency: FETCH ≥1 cycle (1 when rom_ack arrives in the same cycle as rom_req), then EXEC 1 cycle. Minimum 2 cycles per instruction; load 3.
- rom_ack while rom_req=0: ignored.
- Flags: datapath updates Z/C on the EXEC edge. They are sampled by a branch no earlier than 2 cycles later, so back-to-back add then jz is correct.
- run is sampled only at instruction completion and in HALT. Dropping run mid-instruction never aborts that instruction.
- Taken jump to the current pc, or a wrap at 1023: no special case.

## Configuration
- CPU_CTRL_STEP_EN defined:
  - Adds input step (1 bit).
  - In HALT with run=0, a step=1 cycle executes exactly one instruction, then returns to HALT.
  - step is ignored outside HALT.
  - When run=1, run takes precedence over step.
- Undefined: no step port; HALT is left only by run=1.

## Structure
- Shared package cpu_pkg holds:
  - opcode constants (16);
  - alu_op encoding;
  - state enum;
  - field-position constants for IR.
- Sub-module cpu_ctrl_decode: combinational; takes opcode, z_in, c_in; produces strobes, alu_op, jump_taken and is_load. Gated by EXEC in the parent.

## Test plan
- Zero-wait ROM, program mva 5; mvb 4; add → strobes in order a_we(imm=5), b_we(imm=4), a_we+flag_we alu_op=ADD. retired=3 after 6 cycles; pc=3.
- rom_ack delayed 3 cycles on every fetch → rom_addr stable while rom_req=1. Each instruction takes 5 cycles; no strobe during FETCH.
- jz 0x200 with z_in=1 → pc=0x200; with z_in=0 → pc=previous+1. Same for jnc with c_in=0/1.
- load 0x00F → ram_re with ram_addr=0xF in EXEC; a_we with alu_op=RAM next cycle; 3 cycles total.
- run dropped during EXEC of instruction at pc=7 → instruction completes, halted=1, pc=8, rom_req=0. Raising run resumes fetch at 8.
- rst pulsed mid-FETCH with pc=0x3FF → immediate pc=0, rom_req=0, retired=0. Fetch from 0 after release with run=1. With CPU_CTRL_STEP_EN, a single step pulse in HALT → retired+1, back to HALT.
